// File: rtl/muldiv_pkg.sv
// Shared types for the IE-stage RV32M multiply/divide unit.
// Op encodings match funct3 of the RV32M instructions.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ie_muldiv_datapath.sv
// Unsigned shift-add multiply / restoring divide core, one step per strobe.
// hi:lo is the 2*XLEN accumulator (mul) or remainder:quotient (div).
module ie_muldiv_datapath #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            div_q;
  logic [XLEN:0]   sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    if (div_q) begin
      // Restoring step: keep the difference only when it does not go negative.
      if (shifted >= {1'b0, b_q}) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a_mag;
      b_q   <= b_mag;
      div_q <= is_div;
    end else if (step) begin
      hi_q  <= hi_next;
      lo_q  <= lo_next;
    end
  end

endmodule

// File: rtl/ie_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the IE stage.
// Holds the FSM, step counter, special-case detection and final sign fix-up.
module ie_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_ALU_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   counter_q, counter_d;
  muldiv_op_e      op_q, op_d, op_in;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept, load, step;
  logic            sa, sb, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res, final_res, hi_next, lo_next, div_raw;
  logic [2*XLEN-1:0] prod, prod_fix;

  // Magnitude taken in XLEN+1 bits so the most-negative value does not wrap.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN:0] w;
    w = sgn ? (~{1'b1, v}) + (XLEN+1)'(1) : {1'b0, v};
    return w[XLEN-1:0];
  endfunction

  assign op_in  = muldiv_op_e'(funct3);
  assign accept = start & ~flush & ((state_q == IDLE) | (state_q == DONE));

  always_comb begin
    sa = rs1_value[XLEN-1] & ((op_in == OP_MULH) | (op_in == OP_MULHSU) |
                              (op_in == OP_DIV)  | (op_in == OP_REM));
    sb = rs2_ALU_in[XLEN-1] & ((op_in == OP_MULH) | (op_in == OP_DIV) | (op_in == OP_REM));
    neg_in   = (op_in == OP_REM) ? sa : (sa ^ sb);
    a_mag    = mag(rs1_value, sa);
    b_mag    = mag(rs2_ALU_in, sb);
    div_zero = funct3[2] & (rs2_ALU_in == '0);
    div_ovf  = ((op_in == OP_DIV) | (op_in == OP_REM)) &
               (rs1_value == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_ALU_in == '1);
    if (div_zero) special_res = funct3[1] ? rs1_value : '1;
    else          special_res = funct3[1] ? '0 : rs1_value;
  end

  always_comb begin
    prod     = {hi_next, lo_next};
    prod_fix = neg_q ? -prod : prod;
    div_raw  = op_q[1] ? hi_next : lo_next;
    if (!op_q[2]) final_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else          final_res = neg_q ? -div_raw : div_raw;
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    op_d      = op_q;
    neg_d     = neg_q;
    result_d  = result_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d      = op_in;
          neg_d     = neg_in;
          counter_d = '0;
          if (div_zero | div_ovf) begin
            state_d  = DONE;
            result_d = special_res;
          end else begin
            state_d = CALC;
            load    = 1'b1;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          step      = 1'b1;
          counter_d = counter_q + CW'(1);
          // The final step's result is taken straight from the datapath's next value.
          if (counter_q == CW'(XLEN - 1)) begin
            state_d  = DONE;
            result_d = final_res;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
    end
  end

  ie_muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (funct3[2]),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi_next(hi_next),
    .lo_next(lo_next)
  );

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
